// File: rtl/crypto_pkg.sv
// Shared constants and encodings for the UART block bridge.
// Block width derivation and serializer state encodings.
package crypto_pkg;

  localparam int ACK_GUARD = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ACK,
    ST_DONE
  } tx_state_t;

  function automatic int blk_w(input int n);
    return 8 * n;
  endfunction

endpackage

// File: rtl/block_serializer.sv
// Result buffer and byte serializer towards uart_tx.
// Sends the captured block MSB-first with a START/BUSY handshake.
module block_serializer
  import crypto_pkg::*;
#(
  parameter int BLOCK_BYTES = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cap,
  input  logic [blk_w(BLOCK_BYTES)-1:0] res_data,
  input  logic                          tx_busy,
  output logic [7:0]                    tx_data,
  output logic                          tx_start,
  output logic                          tx_idle,
  output logic                          overflow
);

  localparam int W  = blk_w(BLOCK_BYTES);
  localparam int IW = $clog2(BLOCK_BYTES);
  localparam int GW = $clog2(ACK_GUARD);

  tx_state_t     state;
  logic [W-1:0]  out_buf;
  logic [IW-1:0] idx;
  logic [GW-1:0] guard;

  // out_buf shifts left per byte, so its top byte is always byte idx
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      out_buf  <= '0;
      idx      <= '0;
      guard    <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      tx_idle  <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (cap && state != ST_IDLE)
        overflow <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (cap) begin
            out_buf <= res_data;
            idx     <= '0;
            tx_idle <= 1'b0;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (!tx_busy) begin
            tx_data  <= out_buf[W-1 -: 8];
            out_buf  <= {out_buf[W-9:0], 8'h00};
            tx_start <= 1'b1;
            guard    <= '0;
            state    <= ST_ACK;
          end
        end
        ST_ACK: begin
          tx_start <= 1'b0;
          if (tx_busy || guard == GW'(ACK_GUARD - 1))
            state <= ST_DONE;
          else
            guard <= guard + 1'b1;
        end
        ST_DONE: begin
          if (!tx_busy) begin
            if (idx == IW'(BLOCK_BYTES - 1)) begin
              idx     <= '0;
              tx_idle <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_LOAD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_block_bridge.sv
// Byte-to-block bridge between a UART pair and a block cipher core.
// Assembles blocks with timeout resync and serialises results back.
module uart_block_bridge
  import crypto_pkg::*;
#(
  parameter int BLOCK_BYTES    = 8,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int RESULT_DELAY   = 7,
  parameter int RES_VALID_EN   = 1
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          MODE,
  input  logic [7:0]                    RX_DATA,
  input  logic                          RX_READY,
  output logic [blk_w(BLOCK_BYTES)-1:0] BLK_DATA,
  output logic                          BLK_MODE,
  output logic                          BLK_VALID,
  input  logic [blk_w(BLOCK_BYTES)-1:0] RES_DATA,
  input  logic                          RES_VALID,
  output logic [7:0]                    TX_DATA,
  output logic                          TX_START,
  input  logic                          TX_BUSY,
  output logic                          TX_IDLE,
  output logic                          OVERFLOW,
  output logic                          TIMEOUT_EVT
);

  localparam int W    = blk_w(BLOCK_BYTES);
  localparam int SW   = W - 8;
  localparam int CW   = $clog2(BLOCK_BYTES);
  localparam int TLIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int TW   = $clog2(TLIM + 2);
  localparam int DW   = $clog2(RESULT_DELAY + 2);

  logic [SW-1:0] shift;
  logic [CW-1:0] rx_cnt;
  logic [TW-1:0] idle;
  logic          tag;
  logic [DW-1:0] dly;
  logic          dly_run;
  logic          cap;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shift       <= '0;
      rx_cnt      <= '0;
      idle        <= '0;
      tag         <= 1'b1;
      BLK_DATA    <= '0;
      BLK_MODE    <= 1'b1;
      BLK_VALID   <= 1'b0;
      TIMEOUT_EVT <= 1'b0;
    end else begin
      BLK_VALID   <= 1'b0;
      TIMEOUT_EVT <= 1'b0;
      if (RX_READY) begin
        idle  <= '0;
        shift <= SW'({shift, RX_DATA});
        if (rx_cnt == '0)
          tag <= MODE;
        if (rx_cnt == CW'(BLOCK_BYTES - 1)) begin
          BLK_DATA  <= {shift, RX_DATA};
          BLK_MODE  <= tag;
          BLK_VALID <= 1'b1;
          rx_cnt    <= '0;
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
        end
      end else if (TIMEOUT_CYCLES != 0 && rx_cnt != '0) begin
        if (idle == TW'(TLIM)) begin
          rx_cnt      <= '0;
          idle        <= '0;
          TIMEOUT_EVT <= 1'b1;
        end else begin
          idle <= idle + 1'b1;
        end
      end
    end
  end

  // dly counts cycles since BLK_VALID for a combinational core
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dly     <= '0;
      dly_run <= 1'b0;
    end else if (BLK_VALID) begin
      dly     <= DW'(1);
      dly_run <= 1'b1;
    end else if (dly_run) begin
      if (dly == DW'(RESULT_DELAY))
        dly_run <= 1'b0;
      else
        dly <= dly + 1'b1;
    end
  end

  always_comb begin
    cap = 1'b0;
    if (RES_VALID_EN != 0)
      cap = RES_VALID;
    else if (RESULT_DELAY == 0)
      cap = BLK_VALID;
    else
      cap = dly_run && (dly == DW'(RESULT_DELAY));
  end

  block_serializer #(
    .BLOCK_BYTES(BLOCK_BYTES)
  ) u_ser (
    .clk     (CLK),
    .rst_n   (RST_N),
    .cap     (cap),
    .res_data(RES_DATA),
    .tx_busy (TX_BUSY),
    .tx_data (TX_DATA),
    .tx_start(TX_START),
    .tx_idle (TX_IDLE),
    .overflow(OVERFLOW)
  );

endmodule

// File: tb/tb_uart_block_bridge.sv
// Randomised self-checking bench for uart_block_bridge.
// Two instances: 8-byte RES_VALID mode and 16-byte delayed-sample mode.
module tb_uart_block_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rx_cyc = 0;

  logic         a_mode, a_rx_ready, a_blk_mode, a_blk_valid;
  logic [7:0]   a_rx_data, a_tx_data;
  logic [63:0]  a_blk_data, a_res_data;
  logic         a_res_valid, a_tx_start, a_tx_busy, a_tx_idle;
  logic         a_ovf, a_to;

  logic         b_mode, b_rx_ready, b_blk_mode, b_blk_valid;
  logic [7:0]   b_rx_data, b_tx_data;
  logic [127:0] b_blk_data, b_res_data;
  logic         b_res_valid, b_tx_start, b_tx_busy, b_tx_idle;
  logic         b_ovf, b_to;

  uart_block_bridge #(
    .BLOCK_BYTES(8), .TIMEOUT_CYCLES(50),
    .RESULT_DELAY(7), .RES_VALID_EN(1)
  ) dut_a (
    .CLK(clk), .RST_N(rst_n), .MODE(a_mode),
    .RX_DATA(a_rx_data), .RX_READY(a_rx_ready),
    .BLK_DATA(a_blk_data), .BLK_MODE(a_blk_mode),
    .BLK_VALID(a_blk_valid), .RES_DATA(a_res_data),
    .RES_VALID(a_res_valid), .TX_DATA(a_tx_data),
    .TX_START(a_tx_start), .TX_BUSY(a_tx_busy),
    .TX_IDLE(a_tx_idle), .OVERFLOW(a_ovf),
    .TIMEOUT_EVT(a_to)
  );

  uart_block_bridge #(
    .BLOCK_BYTES(16), .TIMEOUT_CYCLES(0),
    .RESULT_DELAY(7), .RES_VALID_EN(0)
  ) dut_b (
    .CLK(clk), .RST_N(rst_n), .MODE(b_mode),
    .RX_DATA(b_rx_data), .RX_READY(b_rx_ready),
    .BLK_DATA(b_blk_data), .BLK_MODE(b_blk_mode),
    .BLK_VALID(b_blk_valid), .RES_DATA(b_res_data),
    .RES_VALID(b_res_valid), .TX_DATA(b_tx_data),
    .TX_START(b_tx_start), .TX_BUSY(b_tx_busy),
    .TX_IDLE(b_tx_idle), .OVERFLOW(b_ovf),
    .TIMEOUT_EVT(b_to)
  );

  // uart_tx models: 10-cycle BUSY after each accepted START
  int a_busy_cnt = 0;
  int b_busy_cnt = 0;
  byte unsigned a_txq[$];
  byte unsigned b_txq[$];
  assign a_tx_busy = (a_busy_cnt != 0);
  assign b_tx_busy = (b_busy_cnt != 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_busy_cnt <= 0;
    end else if (a_busy_cnt != 0) begin
      a_busy_cnt <= a_busy_cnt - 1;
    end else if (a_tx_start) begin
      a_busy_cnt <= 10;
      a_txq.push_back(a_tx_data);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_busy_cnt <= 0;
    end else if (b_busy_cnt != 0) begin
      b_busy_cnt <= b_busy_cnt - 1;
    end else if (b_tx_start) begin
      b_busy_cnt <= 10;
      b_txq.push_back(b_tx_data);
    end
  end

  int a_blk_cnt = 0, a_blk_cyc = 0, a_to_cnt = 0, a_starts = 0;
  int b_blk_cnt = 0, b_starts = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_blk_valid) begin
      a_blk_cnt <= a_blk_cnt + 1;
      a_blk_cyc <= cyc;
    end
    if (a_to) a_to_cnt <= a_to_cnt + 1;
    if (a_tx_start) a_starts <= a_starts + 1;
    if (b_blk_valid) b_blk_cnt <= b_blk_cnt + 1;
    if (b_tx_start) b_starts <= b_starts + 1;
  end

  task automatic check_eq(input string tag, input logic [127:0] got,
                          input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_a(input logic [7:0] d, input int gap);
    a_rx_data  = d;
    a_rx_ready = 1'b1;
    last_rx_cyc = cyc;
    @(negedge clk);
    a_rx_ready = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_b(input logic [7:0] d);
    b_rx_data  = d;
    b_rx_ready = 1'b1;
    @(negedge clk);
    b_rx_ready = 1'b0;
  endtask

  // fm < 0: random MODE on every byte, else MODE held at fm
  task automatic block_a(input logic [63:0] data, input int fm,
                         input bit rgap);
    int n0;
    logic m0;
    n0 = a_blk_cnt;
    m0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_mode = (fm < 0) ? 1'($urandom_range(0, 1)) : 1'(fm);
      if (i == 0) m0 = a_mode;
      send_a(data[63-8*i -: 8],
             (i == 7 || !rgap) ? 0 : int'($urandom_range(0, 5)));
    end
    repeat (2) @(negedge clk);
    check_eq("a_blk_cnt", 128'(a_blk_cnt - n0), 1);
    check_eq("a_blk_data", a_blk_data, data);
    check_eq("a_blk_mode", a_blk_mode, m0);
    check_eq("a_blk_lat", 128'(a_blk_cyc - last_rx_cyc), 1);
  endtask

  task automatic wait_txq_a(input int n);
    int t;
    t = 0;
    while (a_txq.size() < n && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check_eq("a_tx_count", 128'(a_txq.size() >= n), 1);
  endtask

  task automatic wait_txq_b(input int n);
    int t;
    t = 0;
    while (b_txq.size() < n && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check_eq("b_tx_count", 128'(b_txq.size() >= n), 1);
  endtask

  task automatic wait_idle_a();
    int t;
    t = 0;
    while (!a_tx_idle && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq("a_tx_idle", a_tx_idle, 1);
  endtask

  task automatic wait_idle_b();
    int t;
    t = 0;
    while (!b_tx_idle && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq("b_tx_idle", b_tx_idle, 1);
  endtask

  task automatic pulse_res_a(input logic [63:0] r);
    a_res_data  = r;
    a_res_valid = 1'b1;
    @(negedge clk);
    a_res_valid = 1'b0;
  endtask

  task automatic result_a(input logic [63:0] r);
    int s0;
    a_txq.delete();
    s0 = a_starts;
    pulse_res_a(r);
    wait_txq_a(8);
    for (int i = 0; i < a_txq.size(); i++)
      check_eq("a_tx_byte", a_txq[i], r[63-8*i -: 8]);
    wait_idle_a();
    check_eq("a_starts", 128'(a_starts - s0), 8);
  endtask

  // MODE flips after byte 0; RES_DATA is valid only 7 cycles after BLK_VALID
  task automatic block_b(input logic [127:0] data, input logic [127:0] r);
    int n0;
    logic m0;
    n0 = b_blk_cnt;
    m0 = 1'($urandom_range(0, 1));
    for (int i = 0; i < 16; i++) begin
      b_mode = (i == 0) ? m0 : ~m0;
      send_b(data[127-8*i -: 8]);
    end
    check_eq("b_blk_lat", b_blk_valid, 1);
    check_eq("b_blk_data", b_blk_data, data);
    check_eq("b_blk_mode", b_blk_mode, m0);
    for (int k = 0; k <= 8; k++) begin
      b_res_data = (k == 7) ? r
                 : {$urandom(), $urandom(), $urandom(), $urandom()};
      check_eq("b_cap_time", b_tx_idle, 128'(k < 8));
      @(negedge clk);
    end
    b_res_data = '0;
    check_eq("b_blk_cnt", 128'(b_blk_cnt - n0), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  r1, r2;
    logic [127:0] bd, br;
    int t, to0, bc0;

    rst_n = 1'b0;
    a_mode = 1'b1; a_rx_data = '0; a_rx_ready = 1'b0;
    a_res_data = '0; a_res_valid = 1'b0;
    b_mode = 1'b1; b_rx_data = '0; b_rx_ready = 1'b0;
    b_res_data = '0; b_res_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_a_blk_data", a_blk_data, 0);
    check_eq("rst_a_blk_mode", a_blk_mode, 1);
    check_eq("rst_a_blk_valid", a_blk_valid, 0);
    check_eq("rst_a_tx_data", a_tx_data, 0);
    check_eq("rst_a_tx_start", a_tx_start, 0);
    check_eq("rst_a_tx_idle", a_tx_idle, 1);
    check_eq("rst_a_ovf", a_ovf, 0);
    check_eq("rst_a_to", a_to, 0);
    check_eq("rst_b_blk_data", b_blk_data, 0);
    check_eq("rst_b_blk_mode", b_blk_mode, 1);
    check_eq("rst_b_tx_idle", b_tx_idle, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    block_a(64'h3031323334353637, 1, 1'b0);
    result_a(64'h0123456789ABCDEF);

    for (int n = 0; n < 4; n++) begin
      block_a({$urandom(), $urandom()}, -1, 1'b1);
      result_a({$urandom(), $urandom()});
    end
    check_eq("a_ovf_clean", a_ovf, 0);

    to0 = a_to_cnt;
    bc0 = a_blk_cnt;
    for (int i = 0; i < 3; i++) send_a(8'($urandom()), 0);
    repeat (45) @(negedge clk);
    check_eq("a_to_early", 128'(a_to_cnt - to0), 0);
    t = 0;
    while (a_to_cnt == to0 && t < 15) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check_eq("a_to_evt", 128'(a_to_cnt - to0), 1);
    check_eq("a_to_no_blk", 128'(a_blk_cnt - bc0), 0);
    block_a('1, 1, 1'b0);
    check_eq("a_to_quiet", 128'(a_to_cnt - to0), 1);

    r1 = {$urandom(), $urandom()};
    r2 = ~r1;
    a_txq.delete();
    pulse_res_a(r1);
    wait_txq_a(3);
    pulse_res_a(r2);
    @(negedge clk);
    check_eq("a_ovf_set", a_ovf, 1);
    wait_txq_a(8);
    for (int i = 0; i < a_txq.size(); i++)
      check_eq("a_ovf_byte", a_txq[i], r1[63-8*i -: 8]);
    wait_idle_a();
    check_eq("a_ovf_sticky", a_ovf, 1);

    b_txq.delete();
    bd = {$urandom(), $urandom(), $urandom(), $urandom()};
    br = {$urandom(), $urandom(), $urandom(), $urandom()};
    block_b(bd, br);
    wait_txq_b(16);
    for (int i = 0; i < b_txq.size(); i++)
      check_eq("b_tx_byte", b_txq[i], br[127-8*i -: 8]);
    wait_idle_b();

    b_txq.delete();
    block_b({$urandom(), $urandom(), $urandom(), $urandom()},
            {$urandom(), $urandom(), $urandom(), $urandom()});
    for (int i = 0; i < 5; i++) send_b(8'($urandom()));
    wait_txq_b(5);
    t = 0;
    while (!b_tx_start && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_eq("b_start_seen", b_tx_start, 1);
    rst_n = 1'b0;
    #1;
    check_eq("b_rst_start", b_tx_start, 0);
    check_eq("b_rst_idle", b_tx_idle, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("b_rst_blk", b_blk_data, 0);
    check_eq("a_ovf_rst", a_ovf, 0);

    b_txq.delete();
    bd = {$urandom(), $urandom(), $urandom(), $urandom()};
    br = {$urandom(), $urandom(), $urandom(), $urandom()};
    block_b(bd, br);
    wait_txq_b(16);
    for (int i = 0; i < b_txq.size(); i++)
      check_eq("b_fresh_byte", b_txq[i], br[127-8*i -: 8]);
    wait_idle_b();
    check_eq("b_ovf", b_ovf, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
